// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host transmitter.
//   ps2_state_e       : transmit sequencer states
//   PS2_INHIBIT_CYC   : default clock-inhibit hold (100 us at 48 MHz)
//   PS2_TIMEOUT_CYC   : default request-to-send to ack limit (15 ms at 48 MHz)
//   PS2_MAX_RETRY     : retries allowed when PS2_TX_RETRY_EN is defined
//   odd_parity()      : PS/2 parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_RELEASE
  } ps2_state_e;

  localparam int PS2_INHIBIT_CYC = 4800;
  localparam int PS2_TIMEOUT_CYC = 720000;
  localparam int PS2_MAX_RETRY   = 2;

  // Parity bit that makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync -- conditions one raw PS/2 line for the clk_i domain.
//   clk_i    : system clock (clock_48)
//   res_n_i  : asynchronous active-low reset
//   line_i   : raw open-drain line (idles high)
//   level_o  : synchronized, glitch-filtered line level
//   fall_o   : one-cycle pulse when level_o goes 1 -> 0
// A new level is accepted only after it has been stable for 8 cycles.
module ps2_line_sync (
  input  logic clk_i,
  input  logic res_n_i,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic [2:0] flt_cnt_q;
  logic       level_q;
  logic       fall_q;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      sync_q    <= 2'b11;
      flt_cnt_q <= '0;
      level_q   <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == 3'd7) begin
        // eighth consecutive differing sample: commit the new level
        level_q   <= sync_q[1];
        flt_cnt_q <= '0;
        fall_q    <= ~sync_q[1];
      end else begin
        flt_cnt_q <= flt_cnt_q + 3'd1;
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter (e.g. keyboard commands).
//   clk_i, res_n_i            : system clock (clock_48), async active-low reset
//   tx_data_i, tx_req_i       : byte and request, accepted while tx_ready_o=1
//   tx_ready_o                : idle, request will be accepted
//   tx_done_o / tx_err_o      : one-cycle outcome pulses (never together)
//   ps2_clk_i, ps2_dat_i      : raw PS/2 lines
//   ps2_clk_oe_o, ps2_dat_oe_o: 1 = top level pulls the line low
// Optional feature macro PS2_TX_RETRY_EN: on error, resend the same byte up to
// two more times before reporting tx_err_o.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = PS2_INHIBIT_CYC,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_req_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o
);

  localparam int CNT_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [7:0]       data_q, data_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             nack_q, nack_d;
  logic             fail, timeout;
  logic             clk_lvl, clk_fall, dat_lvl, dat_fall_unused;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  ps2_line_sync u_clk_sync (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .line_i  (ps2_clk_i),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .line_i  (ps2_dat_i),
    .level_o (dat_lvl),
    .fall_o  (dat_fall_unused)
  );

  assign bit_nxt = bit_cnt_q + 3'd1;
  assign timeout = (state_q inside {ST_RTS, ST_DATA, ST_PARITY, ST_STOP, ST_ACK}) &&
                   (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    nack_d    = nack_q;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_req_i) begin
          data_d   = tx_data_i;
          state_d  = ST_INHIBIT;
          clk_oe_d = 1'b1;
          cnt_d    = '0;
`ifdef PS2_TX_RETRY_EN
          retry_d  = '0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          // start bit: pull data low, hand the clock to the device
          state_d  = ST_RTS;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RTS, ST_DATA, ST_PARITY, ST_STOP, ST_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        // timeout is checked first so a coincident clock edge is dropped
        if (timeout) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          fail     = 1'b1;
        end else if (clk_fall) begin
          case (state_q)
            ST_RTS: begin
              dat_oe_d  = ~data_q[0];
              bit_cnt_d = '0;
              state_d   = ST_DATA;
            end
            ST_DATA: begin
              if (bit_cnt_q == 3'd7) begin
                dat_oe_d = ~odd_parity(data_q);
                state_d  = ST_PARITY;
              end else begin
                dat_oe_d  = ~data_q[bit_nxt];
                bit_cnt_d = bit_nxt;
              end
            end
            ST_PARITY: begin
              dat_oe_d = 1'b0;
              state_d  = ST_STOP;
            end
            ST_STOP: state_d = ST_ACK;
            ST_ACK: begin
              nack_d  = dat_lvl;
              state_d = ST_RELEASE;
            end
            default: ;
          endcase
        end
      end
      ST_RELEASE: begin
        if (clk_lvl && dat_lvl) begin
          if (nack_q) begin
            fail = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'(PS2_MAX_RETRY)) begin
        retry_d  = retry_q + 2'd1;
        state_d  = ST_INHIBIT;
        clk_oe_d = 1'b1;
        dat_oe_d = 1'b0;
      end else begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
`else
      err_d   = 1'b1;
      state_d = ST_IDLE;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      nack_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      nack_q    <= nack_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign tx_ready_o   = (state_q == ST_IDLE);
  assign tx_done_o    = done_q;
  assign tx_err_o     = err_q;
  assign ps2_clk_oe_o = clk_oe_q;
  assign ps2_dat_oe_o = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host, and the bench compares captured bits and outcome pulses with values it
// derives from the byte sent.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int TMO  = 2000;
  localparam int HALF = 25;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk_i = 1'b0;
  logic       res_n_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_req_i = 1'b0;
  logic       tx_ready_o, tx_done_o, tx_err_o;
  logic       ps2_clk_oe_o, ps2_dat_oe_o;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;

  int errors = 0;
  int checks = 0;

  int cyc = 0, inhibit_phases = 0, inh_run = 0, last_inh = 0;
  int rts_cyc = 0, err_cyc = 0, done_cnt = 0, err_cnt = 0, overlap = 0;
  logic clk_oe_prev = 1'b0;

  assign ps2_clk_line = ~(ps2_clk_oe_o | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe_o | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk_i        (clk_i),
    .res_n_i      (res_n_i),
    .tx_data_i    (tx_data_i),
    .tx_req_i     (tx_req_i),
    .tx_ready_o   (tx_ready_o),
    .tx_done_o    (tx_done_o),
    .tx_err_o     (tx_err_o),
    .ps2_clk_i    (ps2_clk_line),
    .ps2_dat_i    (ps2_dat_line),
    .ps2_clk_oe_o (ps2_clk_oe_o),
    .ps2_dat_oe_o (ps2_dat_oe_o)
  );

  always #5 clk_i = ~clk_i;

  // observers: inhibit phases and lengths, RTS time, outcome pulses
  always @(negedge clk_i) begin
    cyc++;
    if (ps2_clk_oe_o && !clk_oe_prev) inhibit_phases++;
    if (ps2_clk_oe_o) inh_run++;
    else if (clk_oe_prev) begin
      last_inh = inh_run;
      inh_run  = 0;
      if (ps2_dat_oe_o) rts_cyc = cyc;
    end
    clk_oe_prev = ps2_clk_oe_o;
    if (tx_done_o) done_cnt++;
    if (tx_err_o) begin err_cnt++; err_cyc = cyc; end
    if (tx_done_o && tx_err_o) overlap++;
  end

  // reference model of the frame contents
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    return ((int'(b) >> i) % 2) == 1;
  endfunction

  function automatic logic exp_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += (int'(b) >> i) % 2;
    return (ones % 2) == 0;
  endfunction

  // device: waits for request-to-send, then clocks nclk pulses, sampling the
  // data line on each rising edge; after the stop bit it drives the ack level
  task automatic dev_frame(input logic ack_low, input int nclk,
                           output logic [11:0] got, output logic ok);
    int w = 0;
    ok  = 1'b0;
    got = '0;
    while (!(ps2_clk_oe_o === 1'b0 && ps2_dat_oe_o === 1'b1) && w < 5000) begin
      @(negedge clk_i);
      w++;
    end
    if (w < 5000) begin
      ok = 1'b1;
      repeat (30) @(negedge clk_i);
      for (int k = 1; k <= nclk; k++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk_i);
        dev_clk_low = 1'b0;
        got[k-1] = ps2_dat_line;
        if (k == 10) dev_dat_low = ack_low;
        repeat (HALF) @(negedge clk_i);
      end
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_outcome(input int budget, input int d0, input int e0);
    int w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < budget) begin
      @(negedge clk_i);
      w++;
    end
  endtask

  task automatic test_reset;
    res_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", tx_ready_o); end
    checks++; if (tx_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", tx_done_o); end
    checks++; if (tx_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", tx_err_o); end
    checks++; if (ps2_clk_oe_o !== 1'b0) begin errors++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe_o); end
    checks++; if (ps2_dat_oe_o !== 1'b0) begin errors++; $display("FAIL reset_dat_oe got=%b exp=0", ps2_dat_oe_o); end
    res_n_i = 1'b1;
    repeat (20) @(negedge clk_i);
  endtask

  task automatic test_send(input logic [7:0] b);
    logic [11:0] got;
    logic        ok;
    int d0 = done_cnt, e0 = err_cnt, p0 = inhibit_phases;
    @(negedge clk_i);
    tx_data_i = b;
    tx_req_i  = 1'b1;
    @(negedge clk_i);
    tx_req_i  = 1'b0;
    tx_data_i = ~b;
    checks++; if (tx_ready_o !== 1'b0) begin errors++; $display("FAIL send_%h_ready_drop got=%b exp=0", b, tx_ready_o); end
    dev_frame(1'b1, 12, got, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL send_%h_rts got=%b exp=1", b, ok); end
    wait_outcome(300, d0, e0);
    repeat (2) @(negedge clk_i);
    checks++; if (last_inh != INH) begin errors++; $display("FAIL send_%h_inhibit_len got=%0d exp=%0d", b, last_inh, INH); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp_bit(b, i)) begin errors++; $display("FAIL send_%h_bit%0d got=%b exp=%b", b, i, got[i], exp_bit(b, i)); end
    end
    checks++; if (got[8] !== exp_parity(b)) begin errors++; $display("FAIL send_%h_parity got=%b exp=%b", b, got[8], exp_parity(b)); end
    checks++; if (got[9] !== 1'b1) begin errors++; $display("FAIL send_%h_stop got=%b exp=1", b, got[9]); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL send_%h_done got=%0d exp=1", b, done_cnt - d0); end
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL send_%h_err got=%0d exp=0", b, err_cnt - e0); end
    checks++; if (inhibit_phases - p0 != 1) begin errors++; $display("FAIL send_%h_phases got=%0d exp=1", b, inhibit_phases - p0); end
    checks++; if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL send_%h_ready_after got=%b exp=1", b, tx_ready_o); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++) test_send(8'($urandom_range(0, 255)));
  endtask

  task automatic test_timeout;
    int d0 = done_cnt, e0 = err_cnt, p0 = inhibit_phases;
    @(negedge clk_i);
    tx_data_i = 8'hF4;
    tx_req_i  = 1'b1;
    @(negedge clk_i);
    tx_req_i  = 1'b0;
    wait_outcome(ATTEMPTS * (TMO + INH + 100), d0, e0);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (err_cyc - rts_cyc != TMO) begin errors++; $display("FAIL timeout_delay got=%0d exp=%0d", err_cyc - rts_cyc, TMO); end
    checks++; if (ps2_clk_oe_o !== 1'b0 || ps2_dat_oe_o !== 1'b0) begin errors++; $display("FAIL timeout_oe got=%b%b exp=00", ps2_clk_oe_o, ps2_dat_oe_o); end
    checks++; if (inhibit_phases - p0 != ATTEMPTS) begin errors++; $display("FAIL timeout_phases got=%0d exp=%0d", inhibit_phases - p0, ATTEMPTS); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL timeout_done got=%0d exp=0", done_cnt - d0); end
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_nack;
    logic [11:0] got;
    logic        ok;
    int d0 = done_cnt, e0 = err_cnt, p0 = inhibit_phases;
    @(negedge clk_i);
    tx_data_i = 8'hFF;
    tx_req_i  = 1'b1;
    @(negedge clk_i);
    tx_req_i  = 1'b0;
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_frame(1'b0, 12, got, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nack_rts%0d got=%b exp=1", a, ok); end
    end
    wait_outcome(300, d0, e0);
    repeat (3) @(negedge clk_i);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL nack_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL nack_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (inhibit_phases - p0 != ATTEMPTS) begin errors++; $display("FAIL nack_phases got=%0d exp=%0d", inhibit_phases - p0, ATTEMPTS); end
  endtask

  task automatic test_reset_mid;
    logic [11:0] got;
    logic        ok;
    int d0, e0;
    @(negedge clk_i);
    tx_data_i = 8'h5A;
    tx_req_i  = 1'b1;
    @(negedge clk_i);
    tx_req_i  = 1'b0;
    dev_frame(1'b1, 5, got, ok);
    d0 = done_cnt;
    e0 = err_cnt;
    #2 res_n_i = 1'b0;
    #1;
    checks++; if (ps2_clk_oe_o !== 1'b0 || ps2_dat_oe_o !== 1'b0) begin errors++; $display("FAIL rstmid_oe got=%b%b exp=00", ps2_clk_oe_o, ps2_dat_oe_o); end
    @(negedge clk_i);
    checks++; if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", tx_ready_o); end
    repeat (5) @(negedge clk_i);
    res_n_i = 1'b1;
    repeat (20) @(negedge clk_i);
    checks++; if (done_cnt != d0 || err_cnt != e0) begin errors++; $display("FAIL rstmid_pulses got=%0d/%0d exp=0/0", done_cnt - d0, err_cnt - e0); end
    test_send(8'hA5);
  endtask

  task automatic test_hold_req;
    logic [11:0] got;
    logic        ok;
    int d0 = done_cnt, p0 = inhibit_phases, w = 0;
    @(negedge clk_i);
    tx_data_i = 8'h3C;
    tx_req_i  = 1'b1;
    dev_frame(1'b1, 12, got, ok);
    while (!tx_done_o && w < 300) begin
      @(negedge clk_i);
      w++;
    end
    tx_req_i = 1'b0;
    checks++; if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL hold_ready got=%b exp=1", tx_ready_o); end
    repeat (20) @(negedge clk_i);
    checks++; if (inhibit_phases - p0 != 1) begin errors++; $display("FAIL hold_frames got=%0d exp=1", inhibit_phases - p0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL hold_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (got[7:0] !== 8'h3C) begin errors++; $display("FAIL hold_byte got=%h exp=3c", got[7:0]); end
  endtask

  initial begin
    test_reset;
    test_send(8'hED);
    test_send(8'h00);
    test_random;
    test_timeout;
    test_nack;
    test_reset_mid;
    test_hold_req;
    checks++; if (overlap != 0) begin errors++; $display("FAIL done_err_overlap got=%0d exp=0", overlap); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 4800, meaning the clock-inhibit hold time in clk_i cycles (100 us at 48 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 720000, meaning the maximum number of cycles from request-to-send to ack (15 ms).
REQ-003 SHALL have port clk_i, input, 1 bit: system clock (clock_48).
REQ-004 SHALL have port res_n_i, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port tx_data_i, input, 8 bits: command byte to send to the keyboard.
REQ-006 SHALL have port tx_req_i, input, 1 bit: send request, qualified by tx_ready_o.
REQ-007 SHALL have port tx_ready_o, output, 1 bit: idle and able to accept a request.
REQ-008 SHALL have port tx_done_o, output, 1 bit: one-cycle pulse when the device acked the frame.
REQ-009 SHALL have port tx_err_o, output, 1 bit: one-cycle pulse on timeout or missing ack.
REQ-010 SHALL have port ps2_clk_i, input, 1 bit: raw PS/2 clock line.
REQ-011 SHALL have port ps2_dat_i, input, 1 bit: raw PS/2 data line.
REQ-012 SHALL have port ps2_clk_oe_o, input/output role open-drain, output, 1 bit: 1 means the top level drives ps2_clk_io low.
REQ-013 SHALL have port ps2_dat_oe_o, output, 1 bit: 1 means the top level drives ps2_data_io low.

Function
REQ-014 SHALL accept a request when tx_req_i and tx_ready_o are both 1 in the same cycle, latch tx_data_i, and drop tx_ready_o on the next cycle.
REQ-015 SHALL sequence through the states IDLE -> INHIBIT -> RTS -> DATA -> PARITY -> STOP -> ACK -> RELEASE -> IDLE.
REQ-016 In INHIBIT, SHALL assert ps2_clk_oe_o for exactly INHIBIT_CYC cycles.
REQ-017 On leaving INHIBIT, SHALL assert ps2_dat_oe_o, release ps2_clk_oe_o, enter RTS, and start the timeout counter.
REQ-018 Each data bit SHALL be updated on the synchronized falling edge of the PS/2 clock.
REQ-019 SHALL send 8 data bits LSB first, then odd parity, then the stop bit with the data line released.
REQ-020 In ACK, SHALL sample the data line on the next falling edge: 0 means success, 1 means error.
REQ-021 In RELEASE, SHALL wait until both synchronized lines are high, then pulse tx_done_o or tx_err_o and return to IDLE.
REQ-022 If the timeout counter reaches TIMEOUT_CYC in any state from RTS to ACK, SHALL release both lines, pulse tx_err_o, and enter IDLE.
REQ-023 A request asserted while tx_ready_o=0 SHALL be ignored, not queued.
REQ-024 tx_done_o and tx_err_o SHALL never be asserted in the same cycle.
REQ-025 An edge detected in the same cycle as the timeout SHALL lose: the timeout wins.

Reset
REQ-026 While res_n_i=0, outputs SHALL be tx_ready_o=1, tx_done_o=0, tx_err_o=0, ps2_clk_oe_o=0, ps2_dat_oe_o=0; state SHALL be IDLE and counters SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL release both lines immediately, with no done or err pulse.

Configuration
REQ-028 With PS2_TX_RETRY_EN defined, an error SHALL restart from INHIBIT with the same byte, up to 2 retries, and tx_err_o SHALL pulse only after the third failure.
REQ-029 Without PS2_TX_RETRY_EN, the first error SHALL pulse tx_err_o, and the retry counter SHALL be absent.

Structure
REQ-030 Package ps2_pkg SHALL hold the state enum and the default INHIBIT and TIMEOUT cycle constants.
REQ-031 Sub-module ps2_line_sync SHALL provide a 2-flop synchronizer, an 8-cycle glitch filter, and a falling-edge pulse, instantiated once per line.

Verification
REQ-032 Send 0xED with a device model clocking at 12.5 kHz: clock is inhibited for 4800 cycles, data bits are 1,0,1,1,0,1,1,1, parity is 1, stop is released, and the model acks -> one tx_done_o pulse.
REQ-033 Send 0x00: parity bit is 1 -> tx_done_o.
REQ-034 Device never clocks after RTS -> tx_err_o pulses exactly 720000 cycles after RTS and both oe outputs are 0.
REQ-035 Device leaves the ack bit high -> tx_err_o (single pulse without the macro; with PS2_TX_RETRY_EN, 3 INHIBIT phases are observed before tx_err_o).
REQ-036 Assert res_n_i=0 during data bit 4 -> oe outputs are 0 next cycle, tx_ready_o=1, no pulses; a new request then completes normally.
REQ-037 Hold tx_req_i during a transfer -> only one frame is sent; tx_ready_o returns 1 after done.
